// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode types: mux-select packages and rv32i_types with the control word,
// queue entry and M-extension funct3 encodings used by rv32i_decoder and decode_queue.
package pcmux;
    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10
    } pcmux_sel_t;
endpackage

package alumux;
    typedef enum logic {
        rs1_out = 1'b0,
        pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        i_imm   = 3'b000,
        u_imm   = 3'b001,
        b_imm   = 3'b010,
        s_imm   = 3'b011,
        j_imm   = 3'b100,
        rs2_out = 3'b101
    } alumux2_sel_t;
endpackage

package cmpmux;
    typedef enum logic {
        rs2_out = 1'b0,
        i_imm   = 1'b1
    } cmpmux_sel_t;
endpackage

package regfilemux;
    typedef enum logic [3:0] {
        alu_out  = 4'b0000,
        br_en    = 4'b0001,
        u_imm    = 4'b0010,
        lw       = 4'b0011,
        pc_plus4 = 4'b0100,
        lb       = 4'b0101,
        lbu      = 4'b0110,
        lh       = 4'b0111,
        lhu      = 4'b1000
    } regfilemux_sel_t;
endpackage

package rv32i_types;
    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq = 3'b000, bne = 3'b001, blt = 3'b100,
        bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000, sh = 3'b001, sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
        axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        mul = 3'b000, mulh = 3'b001, mulhsu = 3'b010, mulhu = 3'b011,
        div = 3'b100, divu = 3'b101, rem = 3'b110, remu = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        strong_nt = 2'b00, weak_nt = 2'b01, weak_t = 2'b10, strong_t = 2'b11
    } prediction_t;

    typedef struct packed {
        logic [6:0]                   opcode;
        logic [2:0]                   funct3;
        logic [6:0]                   funct7;
        logic [4:0]                   rs1;
        logic [4:0]                   rs2;
        logic [4:0]                   rd;
        rv32i_word                    i_imm;
        rv32i_word                    s_imm;
        rv32i_word                    b_imm;
        rv32i_word                    u_imm;
        rv32i_word                    j_imm;
        rv32i_word                    pc;
        rv32i_word                    pc_target;
        prediction_t                  prediction;
        alu_ops                       aluop;
        branch_funct3_t               cmpop;
        alumux::alumux1_sel_t         alumux1_sel;
        alumux::alumux2_sel_t         alumux2_sel;
        cmpmux::cmpmux_sel_t          cmpmux_sel;
        regfilemux::regfilemux_sel_t  regfilemux_sel;
        pcmux::pcmux_sel_t            pcmux_sel;
        logic                         load_regfile;
        logic                         mem_read;
        logic                         mem_write;
        logic                         muldiv;
    } rv32i_control_word;

    typedef struct packed {
        rv32i_control_word word;
        logic              trap;
        rv32i_word         instr;
    } decode_entry_t;
endpackage

// File: rtl/decode_queue_decoder.sv
// Combinational RV32I decoder: (instr, pc, pc_target, prediction) -> (control word, trap).
// Define DECODE_RV32M_EN to decode op_reg/funct7=0000001 as M-extension instead of trapping.
module rv32i_decoder
    import rv32i_types::*;
(
    input  rv32i_word         instr,
    input  rv32i_word         pc,
    input  rv32i_word         pc_target,
    input  prediction_t       prediction,
    output rv32i_control_word word,
    output logic              trap
);
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        word            = '0;
        trap            = 1'b0;
        word.opcode     = instr[6:0];
        word.funct3     = funct3;
        word.funct7     = funct7;
        word.rs1        = instr[19:15];
        word.rs2        = instr[24:20];
        word.rd         = instr[11:7];
        word.i_imm      = {{21{instr[31]}}, instr[30:20]};
        word.s_imm      = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        word.b_imm      = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        word.u_imm      = {instr[31:12], 12'h000};
        word.j_imm      = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        word.pc         = pc;
        word.pc_target  = pc_target;
        word.prediction = prediction;
        word.aluop      = alu_ops'(funct3);

        case (instr[6:0])
            op_lui: begin
                word.load_regfile   = 1'b1;
                word.regfilemux_sel = regfilemux::u_imm;
            end
            op_auipc: begin
                word.alumux1_sel  = alumux::pc_out;
                word.alumux2_sel  = alumux::u_imm;
                word.aluop        = alu_add;
                word.load_regfile = 1'b1;
            end
            op_jal: begin
                word.alumux1_sel    = alumux::pc_out;
                word.alumux2_sel    = alumux::j_imm;
                word.aluop          = alu_add;
                word.pcmux_sel      = pcmux::alu_out;
                word.regfilemux_sel = regfilemux::pc_plus4;
                word.load_regfile   = 1'b1;
            end
            op_jalr: begin
                word.alumux1_sel    = alumux::rs1_out;
                word.alumux2_sel    = alumux::i_imm;
                word.aluop          = alu_add;
                word.pcmux_sel      = pcmux::alu_mod2;
                word.regfilemux_sel = regfilemux::pc_plus4;
                word.load_regfile   = 1'b1;
            end
            op_br: begin
                word.rd          = 5'd0;
                word.alumux1_sel = alumux::pc_out;
                word.alumux2_sel = alumux::b_imm;
                word.aluop       = alu_add;
                word.cmpmux_sel  = cmpmux::rs2_out;
                if (funct3 == 3'b010 || funct3 == 3'b011) trap = 1'b1;
                else word.cmpop = branch_funct3_t'(funct3);
            end
            op_load: begin
                word.alumux2_sel  = alumux::i_imm;
                word.aluop        = alu_add;
                word.mem_read     = 1'b1;
                word.load_regfile = 1'b1;
                case (funct3)
                    lb:      word.regfilemux_sel = regfilemux::lb;
                    lh:      word.regfilemux_sel = regfilemux::lh;
                    lw:      word.regfilemux_sel = regfilemux::lw;
                    lbu:     word.regfilemux_sel = regfilemux::lbu;
                    lhu:     word.regfilemux_sel = regfilemux::lhu;
                    default: trap = 1'b1;
                endcase
            end
            op_store: begin
                word.rd          = 5'd0;
                word.alumux2_sel = alumux::s_imm;
                word.aluop       = alu_add;
                word.mem_write   = 1'b1;
                if (funct3 > 3'b010) trap = 1'b1;
            end
            op_imm: begin
                word.alumux2_sel  = alumux::i_imm;
                word.load_regfile = 1'b1;
                case (funct3)
                    slt: begin
                        word.cmpop          = blt;
                        word.cmpmux_sel     = cmpmux::i_imm;
                        word.regfilemux_sel = regfilemux::br_en;
                    end
                    sltu: begin
                        word.cmpop          = bltu;
                        word.cmpmux_sel     = cmpmux::i_imm;
                        word.regfilemux_sel = regfilemux::br_en;
                    end
                    sr:      word.aluop = funct7[5] ? alu_sra : alu_srl;
                    default: ;
                endcase
            end
            op_reg: begin
                word.alumux2_sel  = alumux::rs2_out;
                word.load_regfile = 1'b1;
                if (funct7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    word.muldiv = 1'b1;
                    word.aluop  = alu_ops'(muldiv_funct3_t'(funct3));
`else
                    trap = 1'b1;
`endif
                end else begin
                    case (funct3)
                        add:  word.aluop = funct7[5] ? alu_sub : alu_add;
                        sr:   word.aluop = funct7[5] ? alu_sra : alu_srl;
                        slt: begin
                            word.cmpop          = blt;
                            word.cmpmux_sel     = cmpmux::rs2_out;
                            word.regfilemux_sel = regfilemux::br_en;
                        end
                        sltu: begin
                            word.cmpop          = bltu;
                            word.cmpmux_sel     = cmpmux::rs2_out;
                            word.regfilemux_sel = regfilemux::br_en;
                        end
                        default: ;
                    endcase
                end
            end
            default: trap = 1'b1;
        endcase

        // x0 is never written, and a trapping entry must have no architectural side effects.
        if (word.rd == 5'd0) word.load_regfile = 1'b0;
        if (trap) begin
            word.load_regfile = 1'b0;
            word.mem_read     = 1'b0;
            word.mem_write    = 1'b0;
        end
    end
endmodule

// File: rtl/decode_queue.sv
// In-order FIFO of decoded RV32I entries between fetch and issue, with flush and order tag.
// Handshake: a side transfers on a rising edge where its valid && ready are both high.
module decode_queue
    import rv32i_types::*;
#(
    parameter int DEPTH   = 4,
    parameter int ORDER_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_pc_target,
    input  prediction_t                in_prediction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output rv32i_control_word          out_word,
    output logic                       out_trap,
    output logic [31:0]                out_instr,
    output logic [ORDER_W-1:0]         out_order,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    decode_entry_t      mem [DEPTH];
    decode_entry_t      in_entry;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [ORDER_W-1:0] order_q;
    logic               enq, deq;

    rv32i_decoder u_decoder (
        .instr      (in_instr),
        .pc         (in_pc),
        .pc_target  (in_pc_target),
        .prediction (in_prediction),
        .word       (in_entry.word),
        .trap       (in_entry.trap)
    );
    assign in_entry.instr = in_instr;

    // No pass-through when full: a same-cycle dequeue does not open a slot.
    assign in_ready  = rst && !flush && (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    assign out_word  = mem[head_q].word;
    assign out_trap  = mem[head_q].trap;
    assign out_instr = mem[head_q].instr;
    assign out_order = order_q;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (enq) mem[tail_q] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            order_q <= '0;
        end else begin
            // The order tag survives a flush so the monitor sees a gap-free sequence of dequeues.
            if (deq) order_q <= order_q + ORDER_W'(1);
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) tail_q <= tail_q + PTR_W'(1);
                if (deq) head_q <= head_q + PTR_W'(1);
                if (enq && !deq)      count_q <= count_q + CNT_W'(1);
                else if (deq && !enq) count_q <= count_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vector table, fill/drain, concurrent
// enqueue/dequeue, flush and asynchronous reset sequences.
module tb_decode_queue;
    import rv32i_types::*;

    localparam int DEPTH   = 4;
    localparam int ORDER_W = 64;

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                in_instr;
    logic [31:0]                in_pc;
    logic [31:0]                in_pc_target;
    prediction_t                in_prediction;
    logic                       out_valid;
    logic                       out_ready;
    rv32i_control_word          out_word;
    logic                       out_trap;
    logic [31:0]                out_instr;
    logic [ORDER_W-1:0]         out_order;
    logic [$clog2(DEPTH+1)-1:0] count;

    decode_queue #(.DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_pc_target  (in_pc_target),
        .in_prediction (in_prediction),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_word      (out_word),
        .out_trap      (out_trap),
        .out_instr     (out_instr),
        .out_order     (out_order),
        .count         (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]                 instr;
        logic                        trap;
        logic                        load_regfile;
        logic                        mem_read;
        logic                        mem_write;
        logic                        muldiv;
        logic [4:0]                  rd;
        logic                        chk_alu;
        alu_ops                      aluop;
        alumux::alumux2_sel_t        alumux2;
        logic                        chk_sel;
        regfilemux::regfilemux_sel_t rfm;
        pcmux::pcmux_sel_t           pcm;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic [31:0]        exp_q [$];
    logic [ORDER_W-1:0] exp_order;
    int                 n_vec;
    int                 n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    logic       m_trap, m_md, m_chk;
    logic [31:0] head_pc;

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_order = '0;
`ifdef DECODE_RV32M_EN
        m_trap = 1'b0; m_md = 1'b1; m_chk = 1'b1;
`else
        m_trap = 1'b1; m_md = 1'b0; m_chk = 1'b0;
`endif
        //          instr         trap lr   mr   mw   md    rd    chk  aluop    alumux2          chk  rfm                    pcm
        vecs[0]  = '{32'h00500093, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, alu_add, alumux::i_imm,   1'b1, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[1]  = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, alu_add, alumux::i_imm,  1'b0, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[2]  = '{32'h00112023, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, alu_add, alumux::s_imm,   1'b0, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[3]  = '{32'h02208033, m_trap, 1'b0, 1'b0, 1'b0, m_md, 5'd0, m_chk, alu_add, alumux::rs2_out, 1'b0, regfilemux::alu_out, pcmux::pc_plus4};
        vecs[4]  = '{32'h402081B3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, alu_sub, alumux::rs2_out, 1'b1, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[5]  = '{32'h40335293, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, alu_sra, alumux::i_imm,   1'b1, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[6]  = '{32'h0020A3B3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, alu_add, alumux::rs2_out, 1'b1, regfilemux::br_en,    pcmux::pc_plus4};
        vecs[7]  = '{32'h00000263, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, alu_add, alumux::b_imm,   1'b0, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[8]  = '{32'h00002263, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, alu_add, alumux::b_imm,   1'b0, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[9]  = '{32'h000000EF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, alu_add, alumux::j_imm,   1'b1, regfilemux::pc_plus4, pcmux::alu_out};
        vecs[10] = '{32'h00008067, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, alu_add, alumux::i_imm,   1'b1, regfilemux::pc_plus4, pcmux::alu_mod2};
        vecs[11] = '{32'h00812203, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, alu_add, alumux::i_imm,   1'b1, regfilemux::lw,       pcmux::pc_plus4};
        vecs[12] = '{32'h00813203, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, alu_add, alumux::i_imm,   1'b0, regfilemux::alu_out,  pcmux::pc_plus4};
        vecs[13] = '{32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, alu_add, alumux::i_imm,   1'b1, regfilemux::alu_out,  pcmux::pc_plus4};

        rst           = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_instr      = '0;
        in_pc         = '0;
        in_pc_target  = 32'h0000_0100;
        in_prediction = weak_nt;
        out_ready     = 1'b0;

        // reset state
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_order", out_order, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // decode table: each vector goes through an empty queue and is dequeued
        for (int i = 0; i < NV; i++) begin
            push(vecs[i].instr, 32'h1000 + 32'(i * 4));
            #1;
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_order", i), out_order, exp_order);
            check($sformatf("v%0d_instr", i), 64'(out_instr), 64'(vecs[i].instr));
            check($sformatf("v%0d_trap", i), 64'(out_trap), 64'(vecs[i].trap));
            check($sformatf("v%0d_load_regfile", i), 64'(out_word.load_regfile), 64'(vecs[i].load_regfile));
            check($sformatf("v%0d_mem_read", i), 64'(out_word.mem_read), 64'(vecs[i].mem_read));
            check($sformatf("v%0d_mem_write", i), 64'(out_word.mem_write), 64'(vecs[i].mem_write));
            check($sformatf("v%0d_muldiv", i), 64'(out_word.muldiv), 64'(vecs[i].muldiv));
            check($sformatf("v%0d_rd", i), 64'(out_word.rd), 64'(vecs[i].rd));
            if (vecs[i].chk_alu) begin
                check($sformatf("v%0d_aluop", i), 64'(out_word.aluop), 64'(vecs[i].aluop));
                check($sformatf("v%0d_alumux2", i), 64'(out_word.alumux2_sel), 64'(vecs[i].alumux2));
            end
            if (vecs[i].chk_sel) begin
                check($sformatf("v%0d_regfilemux", i), 64'(out_word.regfilemux_sel), 64'(vecs[i].rfm));
                check($sformatf("v%0d_pcmux", i), 64'(out_word.pcmux_sel), 64'(vecs[i].pcm));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_order = exp_order + 1;
        end

        // fill to DEPTH with issue stalled, then drain in order
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_instr = 32'h00500093;
            in_pc    = 32'h2000 + 32'(i * 4);
            #1;
            check($sformatf("fill%0d_in_ready", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) exp_q.push_back(in_pc);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_stable", 64'(out_word.pc), 64'h2000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            head_pc = exp_q.pop_front();
            check($sformatf("drain%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d_pc", i), 64'(out_word.pc), 64'(head_pc));
            check($sformatf("drain%0d_order", i), out_order, exp_order);
            tick();
            exp_order = exp_order + 1;
        end
        out_ready = 1'b0;
        #1;
        check("drained_count", 64'(count), 64'd0);
        check("drained_out_valid", 64'(out_valid), 64'd0);
        check("drained_in_ready", 64'(in_ready), 64'd1);

        // simultaneous enqueue and dequeue keeps count
        push(32'h00500093, 32'h3000);
        in_valid  = 1'b1;
        in_instr  = 32'h00100113;
        in_pc     = 32'h3004;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        exp_order = exp_order + 1;
        #1;
        check("both_count", 64'(count), 64'd1);
        check("both_head_pc", 64'(out_word.pc), 64'h3004);
        check("both_order", out_order, exp_order);
        tick();
        out_ready = 1'b0;
        exp_order = exp_order + 1;

        // flush with a same-cycle enqueue (dropped) and dequeue (honoured)
        push(32'h00500093, 32'h4000);
        push(32'h00500093, 32'h4004);
        push(32'h00500093, 32'h4008);
        #1;
        check("preflush_count", 64'(count), 64'd3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h5000;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_order = exp_order + 1;
        #1;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_order_kept", out_order, exp_order);
        push(32'h00500093, 32'h6000);
        #1;
        check("postflush_valid", 64'(out_valid), 64'd1);
        check("postflush_pc", 64'(out_word.pc), 64'h6000);
        check("postflush_order", out_order, exp_order);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // asynchronous reset mid-cycle with two entries queued
        push(32'h00500093, 32'h7000);
        push(32'h00500093, 32'h7004);
        #1;
        check("prerst_count", 64'(count), 64'd2);
        #1;
        rst = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_order", out_order, 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b1;
        #1;
        check("arst_rel_in_ready", 64'(in_ready), 64'd1);
        check("arst_rel_count", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
